// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioning block.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle: raw pins in, conditioned level/strobes out.
interface button_debounce_if #(
    parameter int N_BUTTONS = 2
);
    logic [N_BUTTONS-1:0] btn_raw;
    logic [N_BUTTONS-1:0] btn_level;
    logic [N_BUTTONS-1:0] btn_press;
    logic [N_BUTTONS-1:0] btn_release;
    logic [N_BUTTONS-1:0] btn_toggle;
    logic [N_BUTTONS-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_toggle, btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_toggle, btn_long
    );
endinterface

// File: rtl/button_debounce_channel.sv
// One button: 2-flop synchroniser, debounce FSM, toggle and registered strobes.
// Long-press hold counter is built only when BUTTON_LONG_PRESS_EN is defined.
module button_debounce_channel
    import button_pkg::*;
#(
    parameter int DEB_CYCLES  = 4,
    parameter int LONG_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic toggle_o,
    output logic long_o
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    localparam logic [1:0] ST_REL = 2'(RELEASED);
    localparam logic [1:0] ST_PW  = 2'(PRESS_WAIT);
    localparam logic [1:0] ST_PR  = 2'(PRESSED);
    localparam logic [1:0] ST_RW  = 2'(RELEASE_WAIT);

    if (DEB_CYCLES < 2) begin : g_chk_deb
        $error("DEB_CYCLES must be at least 2");
    end
    if (LONG_CYCLES < 2) begin : g_chk_long
        $error("LONG_CYCLES must be at least 2");
    end

    logic          meta_q, sync_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, press_q, press_d, release_q, release_d, toggle_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_REL: if (sync_q) begin
                state_d = ST_PW;
                cnt_d   = '0;
            end
            ST_PW: begin
                if (!sync_q)               state_d = ST_REL;
                else if (cnt_q == CNT_MAX) state_d = ST_PR;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            ST_PR: if (!sync_q) begin
                state_d = ST_RW;
                cnt_d   = '0;
            end
            ST_RW: begin
                if (sync_q)                state_d = ST_PR;
                else if (cnt_q == CNT_MAX) state_d = ST_REL;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_REL;
        endcase
    end

    // Outputs are registered from the FSM state, so the level lags the state by one edge.
    assign level_d   = (state_q == ST_PR) || (state_q == ST_RW);
    assign press_d   = level_d & ~level_q;
    assign release_d = ~level_d & level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            state_q   <= ST_REL;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            meta_q    <= raw_i;
            sync_q    <= meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_q ^ press_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign toggle_o  = toggle_q;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          done_q, done_d, long_q, long_d;
    logic          hold_clr;

    // Hold time survives a release bounce; only a fresh press or full release clears it.
    assign hold_clr = (state_q == ST_REL) || ((state_q == ST_PW) && (state_d == ST_PR));
    assign long_d   = (hold_q == HOLD_MAX) && !done_q;

    always_comb begin
        hold_d = hold_q;
        done_d = done_q | long_d;
        if (hold_clr) begin
            hold_d = '0;
            done_d = 1'b0;
        end else if (level_d && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            done_q <= 1'b0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            done_q <= done_d;
            long_q <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Board push-button conditioner: N_BUTTONS independent debounce channels.
// Optional long-press strobe enabled by defining BUTTON_LONG_PRESS_EN.
module button_debounce
    import button_pkg::*;
#(
    parameter int CLK_SPEED     = 12_000_000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int N_BUTTONS     = 2,
    parameter int LONG_PRESS_MS = 1000
) (
    input  logic               clk,
    input  logic               reset,
    button_debounce_if.slave   bus
);
    localparam int DEB_CYCLES  = ms_to_cycles(CLK_SPEED, DEBOUNCE_MS);
    localparam int LONG_CYCLES = ms_to_cycles(CLK_SPEED, LONG_PRESS_MS);

    logic [N_BUTTONS-1:0] level_w, press_w, release_w, toggle_w, long_w;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_debounce_channel #(
            .DEB_CYCLES  (DEB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .raw_i     (bus.btn_raw[i]),
            .level_o   (level_w[i]),
            .press_o   (press_w[i]),
            .release_o (release_w[i]),
            .toggle_o  (toggle_w[i]),
            .long_o    (long_w[i])
        );
    end

    assign bus.btn_level   = level_w;
    assign bus.btn_press   = press_w;
    assign bus.btn_release = release_w;
    assign bus.btn_toggle  = toggle_w;
    assign bus.btn_long    = long_w;

endmodule

// File: tb/tb_button_debounce.sv
// Random and directed stimulus against a run-length model of the debouncer.
module tb_button_debounce;
    localparam int CLK_SPEED = 1000;
    localparam int DEB_MS    = 4;
    localparam int LONG_MS   = 10;
    localparam int NB        = 2;
    localparam int DEB       = CLK_SPEED / 1000 * DEB_MS;
    localparam int LONG      = CLK_SPEED / 1000 * LONG_MS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    button_debounce_if #(.N_BUTTONS(NB)) bif ();

    button_debounce #(
        .CLK_SPEED     (CLK_SPEED),
        .DEBOUNCE_MS   (DEB_MS),
        .N_BUTTONS     (NB),
        .LONG_PRESS_MS (LONG_MS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    // Model: pin delayed two edges, debounced state flips after DEB+1 disagreeing
    // samples in a row, outputs show that state one edge later.
    logic [NB-1:0] m_s1, m_s2, m_stable, m_armed;
    int            m_run [NB];
    int            m_age [NB];
    logic [NB-1:0] e_level, e_press, e_rel, e_tog, e_long;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [NB-1:0] raw, input logic rst);
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_armed = '1;
            e_level = '0; e_press = '0; e_rel = '0; e_tog = '0; e_long = '0;
            for (int c = 0; c < NB; c++) begin
                m_run[c] = 0;
                m_age[c] = 0;
            end
        end else begin
            for (int c = 0; c < NB; c++) begin
                e_press[c] = m_stable[c] & ~e_level[c];
                e_rel[c]   = ~m_stable[c] & e_level[c];
                if (e_press[c]) e_tog[c] = ~e_tog[c];
                e_level[c] = m_stable[c];
                // long strobe: first time the press has been held LONG-1 edges
                e_long[c] = m_armed[c] && (m_age[c] == LONG - 1);
                if (e_long[c]) m_armed[c] = 1'b0;
                if (m_stable[c]) begin
                    if (m_age[c] < LONG - 1) m_age[c]++;
                end else begin
                    m_age[c]   = 0;
                    m_armed[c] = 1'b1;
                end
                if (m_s2[c] != m_stable[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB + 1) begin
                        m_stable[c] = m_s2[c];
                        m_run[c]    = 0;
                        if (m_stable[c]) m_age[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
            end
`ifndef BUTTON_LONG_PRESS_EN
            e_long = '0;
`endif
        end
    endtask

    task automatic step(input logic [NB-1:0] raw, input logic rst);
        bif.btn_raw = raw;
        reset       = rst;
        @(posedge clk);
        model_step(raw, rst);
        #1;
        chk("level",   32'(bif.btn_level),   32'(e_level));
        chk("press",   32'(bif.btn_press),   32'(e_press));
        chk("release", 32'(bif.btn_release), 32'(e_rel));
        chk("toggle",  32'(bif.btn_toggle),  32'(e_tog));
        chk("long",    32'(bif.btn_long),    32'(e_long));
    endtask

    task automatic hold(input logic [NB-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b0);
    endtask

    int rem [NB];
    logic [NB-1:0] cur;
    int n_long, long_k;

    initial begin
        bif.btn_raw = '0;
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 1'b1);
            chk("rst_out", 32'({bif.btn_level, bif.btn_press, bif.btn_release,
                                bif.btn_toggle, bif.btn_long}), 32'd0);
        end
        hold(2'b00, 4);

        // clean press
        for (int k = 0; k < 10; k++) begin
            step(2'b01, 1'b0);
            chk("cp_press", 32'(bif.btn_press[0]),  32'(k == 7));
            chk("cp_level", 32'(bif.btn_level[0]),  32'(k >= 7));
            chk("cp_tog",   32'(bif.btn_toggle[0]), 32'(k >= 7));
        end
        // release glitch of 2 cycles, then real release
        for (int k = 0; k < 8; k++) begin
            step((k < 2) ? 2'b00 : 2'b01, 1'b0);
            chk("rg_rel", 32'(bif.btn_release[0]), 32'd0);
            chk("rg_lvl", 32'(bif.btn_level[0]),   32'd1);
        end
        for (int k = 0; k < 10; k++) begin
            step(2'b00, 1'b0);
            chk("rl_rel", 32'(bif.btn_release[0]), 32'(k == 7));
            chk("rl_lvl", 32'(bif.btn_level[0]),   32'(k < 7));
        end
        // bounce reject then hold
        for (int k = 0; k < 12; k++) begin
            step((k < 3) ? 2'b01 : 2'b00, 1'b0);
            chk("br_press", 32'(bif.btn_press[0]),  32'd0);
            chk("br_tog",   32'(bif.btn_toggle[0]), 32'd1);
        end
        for (int k = 0; k < 10; k++) begin
            step(2'b01, 1'b0);
            chk("bh_press", 32'(bif.btn_press[0]), 32'(k == 7));
        end

        // simultaneous channels from clean reset
        step(2'b00, 1'b1);
        hold(2'b00, 3);
        for (int k = 0; k < 10; k++) begin
            step(2'b11, 1'b0);
            chk("sim_press", 32'(bif.btn_press), (k == 7) ? 32'd3 : 32'd0);
        end
        chk("sim_tog", 32'(bif.btn_toggle), 32'd3);
        hold(2'b01, 12);
        hold(2'b11, 12);
        chk("ch1_tog", 32'(bif.btn_toggle), 32'd1);

        // reset while in PRESS_WAIT, pin held
        hold(2'b00, 12);
        hold(2'b01, 3);
        for (int k = 0; k < 2; k++) begin
            step(2'b01, 1'b1);
            chk("rm_out", 32'({bif.btn_level, bif.btn_press, bif.btn_release,
                               bif.btn_toggle, bif.btn_long}), 32'd0);
        end
        n_long = 0;
        long_k = -1;
        for (int k = 0; k < 28; k++) begin
            step(2'b01, 1'b0);
            if (k <= 8) chk("rm_press", 32'(bif.btn_press[0]), 32'(k == 7));
            if (bif.btn_long[0]) begin
                n_long++;
                long_k = k;
            end
        end
`ifdef BUTTON_LONG_PRESS_EN
        chk("long_n",  32'(n_long), 32'd1);
        chk("long_at", 32'(long_k), 32'd16);
`else
        chk("long_n",  32'(n_long), 32'd0);
`endif

        // random pin activity with occasional reset
        cur = '0;
        for (int c = 0; c < NB; c++) rem[c] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NB; c++) begin
                if (rem[c] == 0) begin
                    cur[c] = 1'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20))
                                                         : int'($urandom_range(1, DEB + 3));
                end
                rem[c]--;
            end
            step(cur, $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions raw board push-buttons before they reach LED, PMOD and test logic in the board bring-up top level.
- Per channel: synchronises the asynchronous pin, debounces it with a counter-based state machine, and produces a clean level, one-cycle press/release strobes and a press-toggled level.
- Sits directly downstream of the button1/button2 pins and upstream of led1/led2 and any mode-select logic.

Parameters:
- CLK_SPEED, 12_000_000, system clock frequency in Hz.
- DEBOUNCE_MS, 10, required stable time in ms. DEB_CYCLES = CLK_SPEED/1000*DEBOUNCE_MS; must be ≥2.
- N_BUTTONS, 2, number of independent button channels.
- LONG_PRESS_MS, 1000, hold time for long-press detection. LONG_CYCLES = CLK_SPEED/1000*LONG_PRESS_MS. Used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  N_BUTTONS  asynchronous button pins, active-high (pressed = 1).
- btn_level  output  N_BUTTONS  debounced level.
- btn_press  output  N_BUTTONS  one-cycle strobe on debounced rising edge.
- btn_release  output  N_BUTTONS  one-cycle strobe on debounced falling edge.
- btn_toggle  output  N_BUTTONS  inverts on every press strobe.
- btn_long  output  N_BUTTONS  one-cycle long-press strobe. Present only with BUTTON_LONG_PRESS_EN; tied 0 otherwise.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high.
- Reset values: all outputs 0, synchroniser flops 0, state RELEASED, counters 0.
- Synchroniser: two-flop chain per channel. sync = second flop. No logic between the two flops.
- FSM per channel, cnt width $clog2(DEB_CYCLES):
  - RELEASED: sync=1 → PRESS_WAIT, cnt←0.
  - PRESS_WAIT: sync=0 → RELEASED, no strobe (bounce rejected). Else if cnt==DEB_CYCLES-1 → PRESSED, level←1, press strobe. Else cnt←cnt+1.
  - PRESSED: sync=0 → RELEASE_WAIT, cnt←0.
  - RELEASE_WAIT: sync=1 → PRESSED, no strobe. Else if cnt==DEB_CYCLES-1 → RELEASED, level←0, release strobe. Else cnt←cnt+1.
- Latency: btn_level changes DEB_CYCLES+2 edges after the edge on which sync first shows the new value. That is DEB_CYCLES+3 edges from the first edge sampling the new pin value, provided the pin holds stable throughout.
- Strobes:
  - btn_press and btn_release are registered and high for exactly the cycle in which btn_level first shows the new value.
  - A glitch shorter than DEB_CYCLES cycles produces no strobe and no level change.
- Toggle: btn_toggle flips on the same edge that raises btn_press. Two presses return it to its original value.
- Channels are fully independent. Simultaneous events on several channels are each reported in the same cycle.
- Reset mid-debounce: the channel returns to RELEASED with level 0 and no strobe, even if the pin is held high. A held button re-qualifies after reset in DEB_CYCLES+3 cycles and emits one press strobe.
- No counter wraps: cnt never exceeds DEB_CYCLES-1.

Optional Feature:
- Macro: BUTTON_LONG_PRESS_EN.
- With the macro defined:
  - Per-channel hold counter of $clog2(LONG_CYCLES) bits. Clears when the FSM enters PRESSED from PRESS_WAIT, and also in RELEASED.
  - Increments in PRESSED and RELEASE_WAIT and saturates at LONG_CYCLES-1.
  - btn_long pulses for one cycle on the edge where the counter reaches LONG_CYCLES-1. At most one pulse per press.
  - A bounce back from RELEASE_WAIT to PRESSED does not clear the hold counter.
- Without the macro: no hold counters are synthesised and btn_long is constant 0.

Decomposition:
- Package button_pkg holds:
  - FSM state enum: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; 2-bit encoding.
  - Function computing cycles from CLK_SPEED and ms.
- Sub-module button_debounce_channel: one synchroniser, FSM, toggle and optional hold counter.
- Top level generates N_BUTTONS instances.

Test Plan:
- All tests use CLK_SPEED=1000, DEBOUNCE_MS=4 (DEB_CYCLES=4), LONG_PRESS_MS=10 (LONG_CYCLES=10), N_BUTTONS=2.
- Clean press: btn_raw[0] 0→1 and held → btn_level[0]=1 and a single btn_press[0] pulse exactly 7 edges later; btn_toggle[0] 0→1 on the same edge.
- Bounce reject: btn_raw[0] high 3 cycles then low → no change on btn_level, btn_press or btn_toggle. Then hold high → press after 7 edges.
- Release bounce: while pressed, drop 2 cycles, restore, then hold low → no release on the glitch; btn_release[0] pulse 7 edges after the final fall; btn_level[0]=0.
- Simultaneous channels: both bits rise on the same edge → btn_press=2'b11 in a single cycle. Second press on channel 1 only → btn_toggle=2'b01.
- Reset mid-operation: assert reset in PRESS_WAIT with the pin held → all outputs 0 during reset. After deassert, a press pulse follows 7 edges later.
- Long press (with macro): hold the button 20 cycles after btn_press → exactly one btn_long pulse, 9 edges after btn_press. Without the macro, btn_long stays 0.
